// File: rtl/timer_counter_gp_if.sv
// Control/status bundle between the APB register block and timer_counter_gp.
// Direction-free names; the modports give each side its view.
interface timer_counter_gp_if #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] ld_val;
  logic             dw;
  logic [PSC_W-1:0] psc;
  logic             auto_rld;
  logic [WIDTH-1:0] rld_val;
  logic             one_shot;
  logic [WIDTH-1:0] cmp_val;
  logic             irq_clr;
  logic [WIDTH-1:0] cnt_out;
  logic             tick_out;
  logic             ovf_flag;
  logic             cmp_flag;
  logic             done;
  logic             irq;

  modport master (
    output en, load, ld_val, dw, psc, auto_rld, rld_val, one_shot, cmp_val, irq_clr,
    input  cnt_out, tick_out, ovf_flag, cmp_flag, done, irq
  );

  modport slave (
    input  en, load, ld_val, dw, psc, auto_rld, rld_val, one_shot, cmp_val, irq_clr,
    output cnt_out, tick_out, ovf_flag, cmp_flag, done, irq
  );
endinterface

// File: rtl/timer_counter_gp.sv
// General-purpose up/down timer with prescaler tick, auto-reload, one-shot,
// compare match and sticky overflow/compare flags folded into irq.
module timer_counter_gp #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input logic               pclk,
  input logic               preset,
  timer_counter_gp_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX     = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

  logic [PSC_W-1:0] psc_cnt;
  logic [WIDTH-1:0] cnt_q;
  logic             tick_q;
  logic             ovf_q;
  logic             cmp_q;
  logic             done_q;

  logic             fire;
  logic             at_end;
  logic             term;
  logic             ovf_set;
  logic             cmp_set;
  logic [WIDTH-1:0] cnt_nxt;

  // Count value after one tick. A one-shot run parks on the terminal value,
  // both when stepping onto it and when already sitting there.
  function automatic logic [WIDTH-1:0] next_count(
    input logic [WIDTH-1:0] cur,
    input logic             down,
    input logic             stop,
    input logic             wrap,
    input logic             arld,
    input logic [WIDTH-1:0] rld
  );
    logic [WIDTH-1:0] res;
    if (stop)
      res = down ? '0 : MAX;
    else if (wrap)
      res = arld ? rld : (down ? MAX : '0);
    else
      res = down ? (cur - ONE) : (cur + ONE);
    return res;
  endfunction

  always_comb begin
    fire    = bus.en && !done_q && !bus.load && (psc_cnt >= bus.psc);
    at_end  = bus.dw ? (cnt_q == '0) : (cnt_q == MAX);
    term    = bus.one_shot &&
              (at_end || (bus.dw ? (cnt_q == ONE) : (cnt_q == MAX - ONE)));
    cnt_nxt = next_count(cnt_q, bus.dw, term, at_end, bus.auto_rld, bus.rld_val);
    ovf_set = fire && (term || at_end);
    cmp_set = fire && (cnt_nxt == bus.cmp_val);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q   <= '0;
      psc_cnt <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cmp_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (bus.load) begin
        cnt_q   <= bus.ld_val;
        psc_cnt <= '0;
        tick_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (!bus.en) begin
        psc_cnt <= '0;
        tick_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (done_q) begin
        tick_q  <= 1'b0;
      end else if (fire) begin
        cnt_q   <= cnt_nxt;
        psc_cnt <= '0;
        tick_q  <= 1'b1;
        if (term)
          done_q <= 1'b1;
      end else begin
        psc_cnt <= psc_cnt + PSC_ONE;
        tick_q  <= 1'b0;
      end
      // A flag set on the same edge as irq_clr takes precedence over the clear.
      ovf_q <= ovf_set || (ovf_q && !bus.irq_clr);
      cmp_q <= cmp_set || (cmp_q && !bus.irq_clr);
    end
  end

  assign bus.cnt_out  = cnt_q;
  assign bus.tick_out = tick_q;
  assign bus.ovf_flag = ovf_q;
  assign bus.cmp_flag = cmp_q;
  assign bus.done     = done_q;
  assign bus.irq      = ovf_q | cmp_q;
endmodule

// File: tb/tb_timer_counter_gp.sv
// Scoreboard bench for timer_counter_gp: directed scenarios then random traffic,
// expectations from a behavioural model pushed per edge and checked by a monitor.
module tb_timer_counter_gp;
  localparam int WIDTH = 8;
  localparam int PSC_W = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic pclk;
  logic preset;

  timer_counter_gp_if #(.WIDTH(WIDTH), .PSC_W(PSC_W)) bus ();

  timer_counter_gp #(.WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int cnt;
    bit tick;
    bit ovf;
    bit cmp;
    bit done;
    bit irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Stimulus for the next edge
  bit s_preset, s_en, s_load, s_dw, s_auto, s_one_shot, s_irq_clr;
  int s_ld_val, s_psc, s_rld, s_cmp;

  // Reference model state
  int m_cnt, m_edges;
  bit m_tick, m_ovf, m_cmp, m_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one edge's worth of inputs and predict the state after that edge.
  task automatic step();
    exp_t e;
    int   nv;
    bit   set_o, set_c;
    @(negedge pclk);
    preset       = s_preset;
    bus.en       = s_en;
    bus.load     = s_load;
    bus.ld_val   = s_ld_val[WIDTH-1:0];
    bus.dw       = s_dw;
    bus.psc      = s_psc[PSC_W-1:0];
    bus.auto_rld = s_auto;
    bus.rld_val  = s_rld[WIDTH-1:0];
    bus.one_shot = s_one_shot;
    bus.cmp_val  = s_cmp[WIDTH-1:0];
    bus.irq_clr  = s_irq_clr;
    set_o = 1'b0;
    set_c = 1'b0;
    if (s_preset) begin
      m_cnt = 0; m_edges = 0; m_tick = 0; m_ovf = 0; m_cmp = 0; m_done = 0;
    end else begin
      if (s_load) begin
        m_cnt = s_ld_val; m_done = 0; m_edges = 0; m_tick = 0;
      end else if (!s_en) begin
        m_edges = 0; m_tick = 0; m_done = 0;
      end else if (m_done) begin
        m_tick = 0;
      end else begin
        m_edges++;
        m_tick = (m_edges >= s_psc + 1);
        if (m_tick) begin
          m_edges = 0;
          if (s_one_shot && (s_dw ? (m_cnt <= 1) : (m_cnt >= MAXV - 1))) begin
            nv = s_dw ? 0 : MAXV; set_o = 1; m_done = 1;
          end else if (!s_dw) begin
            if (m_cnt + 1 > MAXV) begin nv = s_auto ? s_rld : 0; set_o = 1; end
            else nv = m_cnt + 1;
          end else begin
            if (m_cnt - 1 < 0) begin nv = s_auto ? s_rld : MAXV; set_o = 1; end
            else nv = m_cnt - 1;
          end
          set_c = (nv == s_cmp);
          m_cnt = nv;
        end
      end
      m_ovf = set_o || (m_ovf && !s_irq_clr);
      m_cmp = set_c || (m_cmp && !s_irq_clr);
    end
    e.cnt = m_cnt; e.tick = m_tick; e.ovf = m_ovf; e.cmp = m_cmp;
    e.done = m_done; e.irq = m_ovf | m_cmp;
    exp_q.push_back(e);
    s_preset  = 0;
    s_load    = 0;
    s_irq_clr = 0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Sample just after the edge that the last step fed.
  task automatic settle();
    @(posedge pclk);
    #2;
  endtask

  // Monitor: one expected entry per edge that stimulus has fed.
  initial begin
    exp_t e;
    forever begin
      @(posedge pclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cnt_out",  int'(bus.cnt_out),  e.cnt);
        chk("tick_out", int'(bus.tick_out), int'(e.tick));
        chk("ovf_flag", int'(bus.ovf_flag), int'(e.ovf));
        chk("cmp_flag", int'(bus.cmp_flag), int'(e.cmp));
        chk("done",     int'(bus.done),     int'(e.done));
        chk("irq",      int'(bus.irq),      int'(e.irq));
      end
    end
  end

  initial begin
    preset = 1'b0;
    bus.en = 0; bus.load = 0; bus.ld_val = '0; bus.dw = 0; bus.psc = '0;
    bus.auto_rld = 0; bus.rld_val = '0; bus.one_shot = 0; bus.cmp_val = '0; bus.irq_clr = 0;
    s_preset = 0; s_en = 0; s_load = 0; s_dw = 0; s_auto = 0; s_one_shot = 0; s_irq_clr = 0;
    s_ld_val = 0; s_psc = 0; s_rld = 0; s_cmp = 8'hC3;
    m_cnt = 0; m_edges = 0; m_tick = 0; m_ovf = 0; m_cmp = 0; m_done = 0;

    // Reset
    s_preset = 1; step(); settle();
    chk("reset_cnt", int'(bus.cnt_out), 0);
    chk("reset_irq", int'(bus.irq), 0);

    // psc=0: a tick on every enabled edge
    s_en = 1; s_psc = 0; s_dw = 0;
    steps(10); settle();
    chk("psc0_cnt10", int'(bus.cnt_out), 10);
    chk("psc0_tick", int'(bus.tick_out), 1);

    // psc=3: every 4th edge
    s_load = 1; s_ld_val = 0; s_psc = 3; step();
    steps(20); settle();
    chk("psc3_cnt5", int'(bus.cnt_out), 5);

    // Load then count down into auto-reload
    s_load = 1; s_ld_val = 8'h50; s_dw = 1; s_auto = 1; s_rld = 8'h20; s_psc = 0;
    step(); settle();
    chk("load_50", int'(bus.cnt_out), 8'h50);
    step(); settle();
    chk("down_4f", int'(bus.cnt_out), 8'h4F);
    steps(8'h4F); settle();
    chk("down_zero", int'(bus.cnt_out), 0);
    step(); settle();
    chk("reload_20", int'(bus.cnt_out), 8'h20);
    chk("under_ovf", int'(bus.ovf_flag), 1);
    chk("under_irq", int'(bus.irq), 1);

    // One-shot up to MAX
    s_load = 1; s_ld_val = 8'hFE; s_irq_clr = 1; s_dw = 0; s_auto = 0; s_one_shot = 1;
    step();
    step(); settle();
    chk("os_cnt_ff", int'(bus.cnt_out), 8'hFF);
    chk("os_ovf", int'(bus.ovf_flag), 1);
    chk("os_done", int'(bus.done), 1);
    steps(10); settle();
    chk("os_hold_ff", int'(bus.cnt_out), 8'hFF);
    chk("os_hold_tick", int'(bus.tick_out), 0);
    s_load = 1; s_ld_val = 8'h10; step(); settle();
    chk("os_load_clr", int'(bus.done), 0);

    // Compare match and set-beats-clear
    s_one_shot = 0; s_load = 1; s_ld_val = 0; s_irq_clr = 1; s_cmp = 5;
    step();
    steps(4); settle();
    chk("cmp_before", int'(bus.cmp_flag), 0);
    step(); settle();
    chk("cmp_at5_cnt", int'(bus.cnt_out), 5);
    chk("cmp_at5", int'(bus.cmp_flag), 1);
    s_cmp = 6; s_irq_clr = 1; step(); settle();
    chk("cmp_set_wins", int'(bus.cmp_flag), 1);
    s_cmp = 8'h80; s_irq_clr = 1; step(); settle();
    chk("cmp_cleared", int'(bus.cmp_flag), 0);

    // Reset mid-count with both flags set
    s_cmp = 0; s_load = 1; s_ld_val = 8'hFF; step();
    step(); settle();
    chk("wrap_irq", int'(bus.irq), 1);
    s_preset = 1; s_load = 1; s_ld_val = 8'h33; step(); settle();
    chk("midrst_cnt", int'(bus.cnt_out), 0);
    chk("midrst_irq", int'(bus.irq), 0);
    chk("midrst_done", int'(bus.done), 0);

    // Random traffic
    s_psc = 1;
    for (int i = 0; i < 3000; i++) begin
      s_en       = ($urandom_range(0, 99) < 92);
      s_load     = ($urandom_range(0, 99) < 4);
      s_ld_val   = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? MAXV - 1 : 1)
                                               : int'($urandom_range(0, MAXV));
      s_irq_clr  = ($urandom_range(0, 99) < 10);
      s_preset   = ($urandom_range(0, 999) < 5);
      if ($urandom_range(0, 99) < 3) s_dw = ~s_dw;
      if ($urandom_range(0, 99) < 4)
        s_psc = ($urandom_range(0, 99) < 80) ? int'($urandom_range(0, 3))
                                             : int'($urandom_range(0, (1 << PSC_W) - 1));
      if ($urandom_range(0, 99) < 3) s_auto = ~s_auto;
      if ($urandom_range(0, 99) < 2) s_one_shot = ~s_one_shot;
      if ($urandom_range(0, 99) < 5) s_rld = int'($urandom_range(0, MAXV));
      if ($urandom_range(0, 99) < 5) s_cmp = int'($urandom_range(0, MAXV));
      step();
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge pclk);
    #2;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
